// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: fetch constants, fetch FSM encoding and
// the IF/ID bundle layout reused by the decode stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            valid;
    logic            fault;
  } if_id_t;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter: redirect beats every hold condition; advances by one
// word only when fetch is running, not stalled and not faulting.
module pc_reg #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halted,
  input  logic        stall,
  input  logic        fault,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!(halted || stall || fault)) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the ROM address from the PC, checks the
// fetch address and fills the IF/ID register with an instruction or a fault.
module if_stage #(
  parameter logic [31:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int          IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        if_id_fault,
  output logic        fetch_halted,
  output logic [31:0] fetch_count
);
  import riscv_pkg::*;

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  fetch_state_e state;
  logic [31:0]  pc_p0;
  logic         fault_now;
  if_id_t       if_id_p1;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (state == HALT),
    .stall       (stall),
    .fault       (fault_now),
    .pc          (pc_p0)
  );

  // Stage p0: address out to the ROM and fetch-legality check
  assign imem_addr = pc_p0;
  assign fault_now = (pc_p0[1:0] != 2'b00) || (pc_p0 > LAST_PC);

  // Stage p0 -> p1: IF/ID register, fetch FSM and delivered-instruction count
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      if_id_p1    <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0, fault: 1'b0};
      fetch_count <= 32'h0;
    end else if (redirect) begin
      // Flush leaves the old pc in place; only the payload becomes a bubble.
      state          <= RUN;
      if_id_p1.instr <= NOP_INSTR;
      if_id_p1.valid <= 1'b0;
      if_id_p1.fault <= 1'b0;
    end else if (state == RUN && !stall) begin
      if_id_p1.pc    <= pc_p0;
      if_id_p1.valid <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
      if (fault_now) begin
        if_id_p1.instr <= NOP_INSTR;
        if_id_p1.fault <= 1'b1;
        state          <= HALT;
      end else begin
        if_id_p1.instr <= imem_data;
        if_id_p1.fault <= 1'b0;
      end
    end
  end

  assign if_id_pc     = if_id_p1.pc;
  assign if_id_instr  = if_id_p1.instr;
  assign if_id_valid  = if_id_p1.valid;
  assign if_id_fault  = if_id_p1.fault;
  assign fetch_halted = (state == HALT);

endmodule
